// File: rtl/btu_pkg.sv
// -----------------------------------------------------------------------------
// btu_pkg
// Shared definitions for the branch target unit.
//   BR_NONE/BR_COND/BR_JAL/BR_JALR : br_kind encodings
//   SEQ_INC                        : fall-through increment (4-byte instructions)
//   btb_entry_t                    : BTB entry layout for the default build
//                                    (XLEN=32, 16 entries). btb_array declares
//                                    the same layout with parameterised widths.
// -----------------------------------------------------------------------------
package btu_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JALR = 2'd3;

  localparam int SEQ_INC = 4;

  localparam int BTU_XLEN_DEF  = 32;
  localparam int BTU_IDX_W_DEF = 4;
  localparam int BTU_TAG_W_DEF = BTU_XLEN_DEF - BTU_IDX_W_DEF - 2;

  typedef struct packed {
    logic                     valid;
    logic [BTU_TAG_W_DEF-1:0] tag;
    logic [BTU_XLEN_DEF-1:0]  target;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_unit_if.sv
// -----------------------------------------------------------------------------
// branch_target_unit_if
// Bundles the request, result and fetch-lookup signals of branch_target_unit.
//   master : the decode/execute + fetch side (drives requests, out_ready,
//            fetch_pc)
//   slave  : the branch target unit itself
// Handshake rule, on both channels: a transfer happens in a cycle where valid
// and ready are both 1 at the rising clock edge; once valid is raised its
// payload stays stable until the transfer.
// Optional: misalign exists only when BTU_MISALIGN_TRAP_EN is defined.
// -----------------------------------------------------------------------------
interface branch_target_unit_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] I_type;
  logic [XLEN-1:0] J_type;
  logic [XLEN-1:0] B_type;
  logic [1:0]      br_kind;
  logic            br_taken;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_target;
  logic            out_taken;

  logic [XLEN-1:0] fetch_pc;
  logic            pred_hit;
  logic [XLEN-1:0] pred_target;

`ifdef BTU_MISALIGN_TRAP_EN
  logic            misalign;

  modport master (
    output in_valid, PC, rs1, I_type, J_type, B_type, br_kind, br_taken,
    output out_ready, fetch_pc,
    input  in_ready, out_valid, out_target, out_taken, pred_hit, pred_target,
    input  misalign
  );

  modport slave (
    input  in_valid, PC, rs1, I_type, J_type, B_type, br_kind, br_taken,
    input  out_ready, fetch_pc,
    output in_ready, out_valid, out_target, out_taken, pred_hit, pred_target,
    output misalign
  );
`else
  modport master (
    output in_valid, PC, rs1, I_type, J_type, B_type, br_kind, br_taken,
    output out_ready, fetch_pc,
    input  in_ready, out_valid, out_target, out_taken, pred_hit, pred_target
  );

  modport slave (
    input  in_valid, PC, rs1, I_type, J_type, B_type, br_kind, br_taken,
    input  out_ready, fetch_pc,
    output in_ready, out_valid, out_target, out_taken, pred_hit, pred_target
  );
`endif

endinterface

// File: rtl/btb_array.sv
// -----------------------------------------------------------------------------
// btb_array
// Direct-mapped branch target buffer storage.
//   clk, rst_n    : clock, synchronous active-low reset (clears valid bits only)
//   rd_idx_i      : combinational lookup index
//   rd_tag_i      : tag to compare against the looked-up entry
//   rd_hit_o      : entry valid and tag equal
//   rd_target_o   : stored target of the looked-up entry (raw, not masked)
//   wr_set_i      : write valid=1, tag, target at wr_idx_i
//   wr_clr_i      : clear valid at wr_idx_i if its tag equals wr_tag_i
//   wr_idx_i, wr_tag_i, wr_target_i : write port address and data
// Reads see only registered contents, so a write is visible the cycle after.
// BTB_DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module btb_array #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  localparam int IDX_W    = $clog2(BTB_DEPTH),
  localparam int TAG_W    = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_o,
  output logic [XLEN-1:0]  rd_target_o,
  input  logic             wr_set_i,
  input  logic             wr_clr_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_target_i
);

  // Same layout as btu_pkg::btb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t mem_q [BTB_DEPTH];

  assign rd_hit_o    = mem_q[rd_idx_i].valid && (mem_q[rd_idx_i].tag == rd_tag_i);
  assign rd_target_o = mem_q[rd_idx_i].target;

  // Only the valid bits carry reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (wr_set_i) begin
      mem_q[wr_idx_i] <= '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i};
    end else if (wr_clr_i && (mem_q[wr_idx_i].tag == wr_tag_i)) begin
      mem_q[wr_idx_i].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// -----------------------------------------------------------------------------
// branch_target_unit
// Resolves the next PC of one control-flow instruction per cycle and registers
// it (one cycle latency), and trains/serves a direct-mapped BTB.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : branch_target_unit_if.slave
//     in_valid/in_ready, PC, rs1, I_type, J_type, B_type, br_kind, br_taken
//     out_valid/out_ready, out_target, out_taken
//     fetch_pc -> pred_hit, pred_target (0 on miss)
//     misalign (only with BTU_MISALIGN_TRAP_EN)
// Config macro: BTU_MISALIGN_TRAP_EN adds a registered misalign flag and keeps
// misaligned taken results out of the BTB.
// No FSM: the only control state is the output-register valid bit.
// -----------------------------------------------------------------------------
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  branch_target_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Output register. pc_q drops PC[1:0]: only index and tag are needed later.
  logic            out_valid_q,  out_valid_d;
  logic [XLEN-1:0] out_target_q, out_target_d;
  logic            out_taken_q,  out_taken_d;
  logic [XLEN-1:2] pc_q,         pc_d;
  logic [1:0]      kind_q,       kind_d;
`ifdef BTU_MISALIGN_TRAP_EN
  logic            misalign_q,   misalign_d;
`endif

  logic            accept;
  logic            deliver;
  logic [XLEN-1:0] new_target;
  logic            new_taken;
  logic [XLEN-1:0] jalr_sum;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = out_valid_q && bus.out_ready;

  // Target selection; all sums wrap modulo 2^XLEN.
  always_comb begin
    new_target = bus.PC + XLEN'(SEQ_INC);
    new_taken  = 1'b0;
    jalr_sum   = bus.rs1 + bus.I_type;
    unique case (bus.br_kind)
      BR_COND: begin
        if (bus.br_taken) begin
          new_target = bus.PC + bus.B_type;
          new_taken  = 1'b1;
        end
      end
      BR_JAL: begin
        new_target = bus.PC + bus.J_type;
        new_taken  = 1'b1;
      end
      BR_JALR: begin
        new_target = {jalr_sum[XLEN-1:1], 1'b0};
        new_taken  = 1'b1;
      end
      default: ;
    endcase
  end

  // Load on accept; otherwise drain on delivery; otherwise hold (stall).
  always_comb begin
    out_valid_d  = out_valid_q;
    out_target_d = out_target_q;
    out_taken_d  = out_taken_q;
    pc_d         = pc_q;
    kind_d       = kind_q;
`ifdef BTU_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    if (accept) begin
      out_valid_d  = 1'b1;
      out_target_d = new_target;
      out_taken_d  = new_taken;
      pc_d         = bus.PC[XLEN-1:2];
      kind_d       = bus.br_kind;
`ifdef BTU_MISALIGN_TRAP_EN
      misalign_d   = new_taken && (new_target[1:0] != 2'b00);
`endif
    end else if (deliver) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q  <= 1'b0;
      out_target_q <= '0;
      out_taken_q  <= 1'b0;
      pc_q         <= '0;
      kind_q       <= BR_NONE;
`ifdef BTU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_target_q <= out_target_d;
      out_taken_q  <= out_taken_d;
      pc_q         <= pc_d;
      kind_q       <= kind_d;
`ifdef BTU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_target = out_target_q;
  assign bus.out_taken  = out_taken_q;
`ifdef BTU_MISALIGN_TRAP_EN
  assign bus.misalign   = misalign_q;
`endif

  // Training fires once per delivered result, from the registered PC.
  logic train_set;
  logic train_clr;

`ifdef BTU_MISALIGN_TRAP_EN
  assign train_set = deliver && out_taken_q && !misalign_q;
`else
  assign train_set = deliver && out_taken_q;
`endif
  assign train_clr = deliver && !out_taken_q && (kind_q == BR_COND);

  logic            rd_hit;
  logic [XLEN-1:0] rd_target;

  btb_array #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (CLK),
    .rst_n       (RST_N),
    .rd_idx_i    (bus.fetch_pc[IDX_W+1:2]),
    .rd_tag_i    (bus.fetch_pc[XLEN-1:IDX_W+2]),
    .rd_hit_o    (rd_hit),
    .rd_target_o (rd_target),
    .wr_set_i    (train_set),
    .wr_clr_i    (train_clr),
    .wr_idx_i    (pc_q[IDX_W+1:2]),
    .wr_tag_i    (pc_q[XLEN-1:IDX_W+2]),
    .wr_target_i (out_target_q)
  );

  assign bus.pred_hit    = rd_hit;
  assign bus.pred_target = rd_hit ? rd_target : '0;

  // Byte offset of fetch_pc does not participate in the lookup.
  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^bus.fetch_pc[1:0];

endmodule
